// File: rtl/stack_pkg.sv
// stack_pkg: shared types and helpers for param_stack_fifo and the stack class model.
package stack_pkg;

    typedef enum logic {
        STACK_LIFO = 1'b0,
        STACK_FIFO = 1'b1
    } stack_mode_e;

    // Word type shared with the class-based stack model.
    typedef logic [7:0] vec8;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_stack_fifo_if.sv
// param_stack_fifo_if: request/response bundle between producer/consumer and the buffer.
// With PARAM_STACK_PEEK_EN defined the bundle also carries peek_data/peek_valid.
interface param_stack_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
);
    localparam int CW = stack_pkg::clog2_cnt(DEPTH);

    logic             push_en;
    logic [WIDTH-1:0] push_data;
    logic             pop_en;
    logic             clr_err;
    logic             push_ok;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
`ifdef PARAM_STACK_PEEK_EN
    logic [WIDTH-1:0] peek_data;
    logic             peek_valid;
`endif

    // Producer/consumer side.
    modport master (
        output push_en, push_data, pop_en, clr_err,
        input  push_ok, pop_valid, pop_data, full, empty, count, overflow, underflow
`ifdef PARAM_STACK_PEEK_EN
        , input peek_data, peek_valid
`endif
    );

    // Buffer side.
    modport slave (
        input  push_en, push_data, pop_en, clr_err,
        output push_ok, pop_valid, pop_data, full, empty, count, overflow, underflow
`ifdef PARAM_STACK_PEEK_EN
        , output peek_data, peek_valid
`endif
    );

endinterface

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array, one write port, one registered read port.
// Kept separate so a RAM macro can be dropped in later without touching control.
// PARAM_STACK_PEEK_EN adds a combinational look-through of the read address.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
`ifdef PARAM_STACK_PEEK_EN
    , output logic [WIDTH-1:0] peek_data
`endif
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Storage write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data only moves on an accepted read, so it holds between pops.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    // Registered read port, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`ifdef PARAM_STACK_PEEK_EN
    assign peek_data = mem[raddr];
`endif

endmodule

// File: rtl/param_stack_fifo.sv
// param_stack_fifo: parametrised LIFO/FIFO buffer with status flags, occupancy count
// and sticky overflow/underflow. Optional PARAM_STACK_PEEK_EN exposes the next pop word.
module param_stack_fifo
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    parameter int MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    param_stack_fifo_if.slave bus
);
    localparam int          CW     = clog2_cnt(DEPTH);
    localparam int          AW     = $clog2(DEPTH);
    localparam stack_mode_e MODE_E = (MODE == 1) ? STACK_FIFO : STACK_LIFO;

    logic [CW-1:0] count_q, count_d;
    logic          push_ok_q, push_ok_d;
    logic          pop_valid_q, pop_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full, empty, push_acc, pop_acc;
    logic [AW-1:0] wr_addr, rd_addr;

    // Acceptance, occupancy update and sticky error flags (a new error beats clr_err).
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        pop_acc     = bus.pop_en && !empty;
        push_acc    = bus.push_en && (!full || pop_acc);
        count_d     = count_q;
        if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
        else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
        push_ok_d   = push_acc;
        pop_valid_d = pop_acc;
        overflow_d  = (bus.push_en && !push_acc) || (overflow_q && !bus.clr_err);
        underflow_d = (bus.pop_en && !pop_acc) || (underflow_q && !bus.clr_err);
    end

    // Control state; reset drops any in-flight response pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            push_ok_q   <= 1'b0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            push_ok_q   <= push_ok_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (MODE_E == STACK_FIFO) begin : g_fifo
            logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

            // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push_acc) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
                if (pop_acc)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end

            // FIFO pointer registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            assign wr_addr = wr_ptr_q;
            assign rd_addr = rd_ptr_q;
        end else begin : g_lifo
            // Top of stack is count itself; a push alongside a pop reuses the popped slot.
            always_comb begin
                rd_addr = AW'(count_q - CW'(1));
                wr_addr = pop_acc ? rd_addr : AW'(count_q);
            end
        end
    endgenerate

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_acc),
        .waddr (wr_addr),
        .wdata (bus.push_data),
        .re    (pop_acc),
        .raddr (rd_addr),
        .rdata (bus.pop_data)
`ifdef PARAM_STACK_PEEK_EN
        , .peek_data (bus.peek_data)
`endif
    );

    assign bus.push_ok   = push_ok_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`ifdef PARAM_STACK_PEEK_EN
    assign bus.peek_valid = !empty;
`endif

endmodule

// File: doc/param_stack_fifo.md
Name: param_stack_fifo

Overview:
- Synthesizable, parametrised storage buffer; hardware successor of the team's class-based stack verification model.
- Generalised in data width, depth and ordering mode (LIFO or FIFO), with status flags, a count output and sticky error flags.
- Sits between a producer and a consumer inside the class-review sandbox designs.
- Used as a DUT alongside the stack class model, which serves as its reference.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 5, number of entries (>=2, need not be a power of 2)
MODE, 0, 0 = LIFO (stack), 1 = FIFO (queue)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
push_en  in  1  push request
push_data  in  WIDTH  data to push
pop_en  in  1  pop request
clr_err  in  1  clears the sticky error flags
push_ok  out  1  registered pulse: push accepted (the hardware ret=1)
pop_valid  out  1  registered pulse: pop accepted, pop_data valid
pop_data  out  WIDTH  popped word, registered
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a push was rejected
underflow  out  1  sticky: a pop was rejected

Behaviour:
- Reset (async assert, sync release): count=0, pointers=0, empty=1, full=0, push_ok=0, pop_valid=0, pop_data=0, overflow=0, underflow=0. Storage contents are not reset.
- Push acceptance: push_en && (!full || pop_accepted).
- Pop acceptance: pop_en && !empty.
- Response latency:
  - push_ok and pop_valid assert exactly 1 cycle after the request.
  - pop_data holds its value until the next accepted pop.
- Rejected push: count unchanged, overflow set next cycle, push_ok=0.
- Rejected pop: count unchanged, underflow set next cycle, pop_valid=0.
- Error flags: overflow/underflow stay set until clr_err=1. If set and clear occur in the same cycle, set wins.
- LIFO (MODE=0):
  - Single top pointer equal to count.
  - Push writes mem[count] and increments count.
  - Pop reads mem[count-1] and decrements count.
- FIFO (MODE=1):
  - Separate wr_ptr and rd_ptr, each wrapping DEPTH-1 -> 0; wrap must be correct for non-power-of-2 depths.
  - count tracks occupancy.
- Simultaneous push and pop, not empty:
  - Both are accepted; count is unchanged.
  - LIFO: pop_data = old top; the new data overwrites the same slot.
  - FIFO: read at rd_ptr, write at wr_ptr, both pointers advance.
  - This holds when full as well.
- Simultaneous push and pop, empty: pop is rejected (underflow set); push is accepted, so count becomes 1. No pass-through.
- Flags: full and empty are combinational decodes of registered count; no extra latency.
- Reset mid-operation: in-flight push_ok/pop_valid pulses are dropped and all state returns to reset values.
- Arithmetic: count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: PARAM_STACK_PEEK_EN.
- Defined: adds output peek_data [WIDTH] and peek_valid (= !empty).
  - peek_data is combinational: the next element a pop would return (LIFO mem[count-1], FIFO mem[rd_ptr]).
  - Peeking does not modify state.
- Undefined: both ports are absent and behaviour is otherwise identical.

Decomposition:
- Package stack_pkg holds:
  - typedef enum {STACK_LIFO=0, STACK_FIFO=1} stack_mode_e
  - function clog2_cnt(depth) returning the count width
  - typedef logic [7:0] vec8, shared with the class model
- Sub-module stack_mem: DEPTH x WIDTH register array, one write port, one registered read port. It is the single point to swap in a RAM macro later.
- Control (pointers, count, flags, handshakes) stays in param_stack_fifo.

Test Plan:
- LIFO, WIDTH=32, DEPTH=5: push 10, push 20, pop -> push_ok pulses twice; pop_valid with pop_data=20; count=1.
- LIFO, WIDTH=8, DEPTH=4: push A5, push 5A, pop, pop -> pop_data 5A then A5; empty=1 afterwards; count sequence 1,2,1,0.
- FIFO, DEPTH=5: push 1..5, push 6 -> full=1, 6 rejected, overflow=1, push_ok=0 for 6. Then pop 5 times -> 1,2,3,4,5. Then pop again -> underflow=1.
- FIFO, DEPTH=5 wrap: 12 interleaved push/pop pairs with values 0..11 -> output order 0..11; pointers wrap past index 4; count constant at 1 after the first push.
- LIFO, full (DEPTH=4 holding 1,2,3,4): simultaneous push 9 and pop -> pop_data=4; count stays 4; next pop returns 9.
- Async reset asserted mid-burst with count=3 and overflow=1 -> all outputs return to reset values immediately, without waiting for a clock edge; clr_err test: a set/clear collision leaves the flag set.
